multicycle_fsm: RTL and testbench

Control state machine for the multicycle CPU. Sequences every datapath register (PC, IR, A, B, ALUOut, MDR, register file) by driving their write enables and the datapath mux selects, one state per cycle. It handshakes with the shared instruction/data memory through `memready`. It halts on an unsupported instruction.

---
 rtl/multicycle_fsm_if.sv | 37 +++
 rtl/multicycle_fsm.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_fsm.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath/memory.
// The FSM side takes the master modport; the datapath side takes the slave modport.
interface multicycle_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       pcwe;
  logic       irwe;
  logic       awe;
  logic       bwe;
  logic       aluoutwe;
  logic       mdrwe;
  logic       regwe;
  logic       memwe;
  logic       iord;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic [1:0] regdst;
  logic [1:0] wbsel;
  logic [3:0] state;
  logic       illegal;

  modport master (
    input  opcode, funct, zero, memready,
    output pcwe, irwe, awe, bwe, aluoutwe, mdrwe, regwe, memwe,
    output iord, alusrca, alusrcb, aluop, pcsrc, regdst, wbsel, state, illegal
  );

  modport slave (
    output opcode, funct, zero, memready,
    input  pcwe, irwe, awe, bwe, aluoutwe, mdrwe, regwe, memwe,
    input  iord, alusrca, alusrcb, aluop, pcsrc, regdst, wbsel, state, illegal
  );
endinterface

// File: rtl/multicycle_fsm.sv
// Control FSM for the multicycle CPU: one state per cycle, sequencing datapath
// register enables and mux selects, stalling on memready, halting on bad opcodes.
module multicycle_fsm (
  input  logic             clk,
  input  logic             resetn,
  multicycle_fsm_if.master bus
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_SLT = 2'b10;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEMADDR  = 4'd4,
    MEMREAD  = 4'd5,
    MEMWRITE = 4'd6,
    WB_R     = 4'd7,
    WB_I     = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd12
  } state_t;

  state_t     state_q, state_d;

  logic       pcwe, irwe, awe, bwe, aluoutwe, mdrwe, regwe, memwe;
  logic       iord, alusrca, illegal;
  logic [1:0] alusrcb, aluop, pcsrc, regdst, wbsel;
  logic       is_r_alu;

  assign is_r_alu = (bus.opcode == OP_R) &&
                    ((bus.funct == FN_ADD) || (bus.funct == FN_SUB) || (bus.funct == FN_SLT));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= FETCH;
    else         state_q <= state_d;
  end

  // Next state and outputs; everything is held at zero while reset is asserted.
  always_comb begin
    state_d  = state_q;
    pcwe     = 1'b0;
    irwe     = 1'b0;
    awe      = 1'b0;
    bwe      = 1'b0;
    aluoutwe = 1'b0;
    mdrwe    = 1'b0;
    regwe    = 1'b0;
    memwe    = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = ALU_ADD;
    pcsrc    = 2'b00;
    regdst   = 2'b00;
    wbsel    = 2'b00;
    illegal  = 1'b0;

    if (resetn) begin
      case (state_q)
        FETCH: begin
          alusrcb = 2'b01;
          irwe    = bus.memready;
          pcwe    = bus.memready;
          if (bus.memready) state_d = DECODE;
        end
        DECODE: begin
          awe      = 1'b1;
          bwe      = 1'b1;
          aluoutwe = 1'b1;
          alusrcb  = 2'b11;
          if (is_r_alu)                                         state_d = EXEC_R;
          else if ((bus.opcode == OP_R) && (bus.funct == FN_JR)) state_d = JUMP;
          else if (bus.opcode == OP_ADDI)                         state_d = EXEC_I;
          else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) state_d = MEMADDR;
          else if ((bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE)) state_d = BRANCH;
          else if ((bus.opcode == OP_J) || (bus.opcode == OP_JAL)) state_d = JUMP;
          else                                                    state_d = HALT;
        end
        EXEC_R: begin
          alusrca  = 1'b1;
          aluoutwe = 1'b1;
          case (bus.funct)
            FN_SUB:  aluop = ALU_SUB;
            FN_SLT:  aluop = ALU_SLT;
            default: aluop = ALU_ADD;
          endcase
          state_d = WB_R;
        end
        WB_R: begin
          regwe   = 1'b1;
          regdst  = 2'b01;
          state_d = FETCH;
        end
        EXEC_I: begin
          alusrca  = 1'b1;
          alusrcb  = 2'b10;
          aluoutwe = 1'b1;
          state_d  = WB_I;
        end
        WB_I: begin
          regwe   = 1'b1;
          state_d = FETCH;
        end
        MEMADDR: begin
          alusrca  = 1'b1;
          alusrcb  = 2'b10;
          aluoutwe = 1'b1;
          state_d  = (bus.opcode == OP_SW) ? MEMWRITE : MEMREAD;
        end
        MEMREAD: begin
          iord  = 1'b1;
          mdrwe = bus.memready;
          if (bus.memready) state_d = WB_MEM;
        end
        MEMWRITE: begin
          iord  = 1'b1;
          memwe = 1'b1;
          if (bus.memready) state_d = FETCH;
        end
        WB_MEM: begin
          regwe   = 1'b1;
          wbsel   = 2'b01;
          state_d = FETCH;
        end
        BRANCH: begin
          alusrca = 1'b1;
          aluop   = ALU_SUB;
          pcsrc   = 2'b01;
          pcwe    = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
          state_d = FETCH;
        end
        JUMP: begin
          pcwe = 1'b1;
          if (bus.opcode == OP_R) begin
            pcsrc = 2'b11;
          end else begin
            pcsrc = 2'b10;
            if (bus.opcode == OP_JAL) begin
              regwe  = 1'b1;
              regdst = 2'b10;
              wbsel  = 2'b10;
            end
          end
          state_d = FETCH;
        end
        HALT: begin
          illegal = 1'b1;
        end
        default: state_d = HALT;
      endcase
    end
  end

  assign bus.pcwe     = pcwe;
  assign bus.irwe     = irwe;
  assign bus.awe      = awe;
  assign bus.bwe      = bwe;
  assign bus.aluoutwe = aluoutwe;
  assign bus.mdrwe    = mdrwe;
  assign bus.regwe    = regwe;
  assign bus.memwe    = memwe;
  assign bus.iord     = iord;
  assign bus.alusrca  = alusrca;
  assign bus.alusrcb  = alusrcb;
  assign bus.aluop    = aluop;
  assign bus.pcsrc    = pcsrc;
  assign bus.regdst   = regdst;
  assign bus.wbsel    = wbsel;
  assign bus.state    = state_q;
  assign bus.illegal  = illegal;

endmodule

// File: tb/tb_multicycle_fsm.sv
// Directed-vector bench for multicycle_fsm: per-cycle table of inputs and
// hand-computed outputs, plus hand sequences for async reset and HALT.
module tb_multicycle_fsm;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  multicycle_fsm_if bus();

  multicycle_fsm dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic       rstn;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       mr;
    logic [3:0] st;
    logic [7:0] en;   // pcwe irwe awe bwe aluoutwe mdrwe regwe memwe
    logic [11:0] sel; // iord alusrca alusrcb aluop pcsrc regdst wbsel
    logic       ill;
  } vec_t;

  localparam logic [7:0] EN_0    = 8'h00;
  localparam logic [7:0] EN_FET  = 8'hC0;
  localparam logic [7:0] EN_DEC  = 8'h38;
  localparam logic [7:0] EN_ALUO = 8'h08;
  localparam logic [7:0] EN_MDR  = 8'h04;
  localparam logic [7:0] EN_REG  = 8'h02;
  localparam logic [7:0] EN_MEMW = 8'h01;
  localparam logic [7:0] EN_PC   = 8'h80;
  localparam logic [7:0] EN_JAL  = 8'h82;

  localparam logic [11:0] SL_0     = 12'h000;
  localparam logic [11:0] SL_FET   = {1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [11:0] SL_DEC   = {1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [11:0] SL_EXADD = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [11:0] SL_EXSUB = {1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [11:0] SL_EXSLT = {1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [11:0] SL_EXI   = {1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [11:0] SL_WBR   = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
  localparam logic [11:0] SL_MEM   = {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [11:0] SL_WBM   = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
  localparam logic [11:0] SL_BR    = {1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
  localparam logic [11:0] SL_J     = {1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [11:0] SL_JAL   = {1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10};
  localparam logic [11:0] SL_JR    = {1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  en_act;
  logic [11:0] sel_act;
  assign en_act  = {bus.pcwe, bus.irwe, bus.awe, bus.bwe, bus.aluoutwe, bus.mdrwe, bus.regwe, bus.memwe};
  assign sel_act = {bus.iord, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc, bus.regdst, bus.wbsel};

  function automatic vec_t mk(logic rstn, logic [5:0] op, logic [5:0] fn, logic z, logic mr,
                              logic [3:0] st, logic [7:0] en, logic [11:0] sel, logic ill);
    vec_t v;
    v.rstn = rstn; v.op = op; v.fn = fn; v.z = z; v.mr = mr;
    v.st = st; v.en = en; v.sel = sel; v.ill = ill;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance one clock.
  task automatic apply(input vec_t v, input int idx);
    resetn       = v.rstn;
    bus.opcode   = v.op;
    bus.funct    = v.fn;
    bus.zero     = v.z;
    bus.memready = v.mr;
    @(negedge clk);
    check("state",   idx, 16'(bus.state),   16'(v.st));
    check("enables", idx, 16'(en_act),      16'(v.en));
    check("selects", idx, 16'(sel_act),     16'(v.sel));
    check("illegal", idx, 16'(bus.illegal), 16'(v.ill));
    @(posedge clk);
    #1;
  endtask

  task automatic add_fd(input logic [5:0] op, input logic [5:0] fn, input logic z);
    vecs.push_back(mk(1, op, fn, z, 1, 4'd0, EN_FET, SL_FET, 0));
    vecs.push_back(mk(1, op, fn, z, 1, 4'd1, EN_DEC, SL_DEC, 0));
  endtask

  initial begin
    resetn = 1'b0;
    bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.memready = 1'b1;

    // reset holds everything at zero even with memready high
    vecs.push_back(mk(0, 6'h00, 6'h20, 0, 1, 4'd0, EN_0, SL_0, 0));
    vecs.push_back(mk(0, 6'h00, 6'h20, 0, 1, 4'd0, EN_0, SL_0, 0));
    // ADD
    add_fd(6'h00, 6'h20, 0);
    vecs.push_back(mk(1, 6'h00, 6'h20, 0, 1, 4'd2, EN_ALUO, SL_EXADD, 0));
    vecs.push_back(mk(1, 6'h00, 6'h20, 0, 1, 4'd7, EN_REG,  SL_WBR,   0));
    // SUB
    add_fd(6'h00, 6'h22, 0);
    vecs.push_back(mk(1, 6'h00, 6'h22, 0, 1, 4'd2, EN_ALUO, SL_EXSUB, 0));
    vecs.push_back(mk(1, 6'h00, 6'h22, 0, 1, 4'd7, EN_REG,  SL_WBR,   0));
    // SLT
    add_fd(6'h00, 6'h2A, 0);
    vecs.push_back(mk(1, 6'h00, 6'h2A, 0, 1, 4'd2, EN_ALUO, SL_EXSLT, 0));
    vecs.push_back(mk(1, 6'h00, 6'h2A, 0, 1, 4'd7, EN_REG,  SL_WBR,   0));
    // ADDI
    add_fd(6'h08, 6'h00, 0);
    vecs.push_back(mk(1, 6'h08, 6'h00, 0, 1, 4'd3, EN_ALUO, SL_EXI, 0));
    vecs.push_back(mk(1, 6'h08, 6'h00, 0, 1, 4'd8, EN_REG,  SL_0,   0));
    // SW with one stall cycle in MEMWRITE
    add_fd(6'h2B, 6'h00, 0);
    vecs.push_back(mk(1, 6'h2B, 6'h00, 0, 1, 4'd4, EN_ALUO, SL_EXI, 0));
    vecs.push_back(mk(1, 6'h2B, 6'h00, 0, 0, 4'd6, EN_MEMW, SL_MEM, 0));
    vecs.push_back(mk(1, 6'h2B, 6'h00, 0, 1, 4'd6, EN_MEMW, SL_MEM, 0));
    // LW: 2 stalls in FETCH, 3 in MEMREAD -> 10 cycles
    vecs.push_back(mk(1, 6'h23, 6'h00, 0, 0, 4'd0, EN_0,    SL_FET, 0));
    vecs.push_back(mk(1, 6'h23, 6'h00, 0, 0, 4'd0, EN_0,    SL_FET, 0));
    add_fd(6'h23, 6'h00, 0);
    vecs.push_back(mk(1, 6'h23, 6'h00, 0, 1, 4'd4, EN_ALUO, SL_EXI, 0));
    vecs.push_back(mk(1, 6'h23, 6'h00, 0, 0, 4'd5, EN_0,    SL_MEM, 0));
    vecs.push_back(mk(1, 6'h23, 6'h00, 0, 0, 4'd5, EN_0,    SL_MEM, 0));
    vecs.push_back(mk(1, 6'h23, 6'h00, 0, 0, 4'd5, EN_0,    SL_MEM, 0));
    vecs.push_back(mk(1, 6'h23, 6'h00, 0, 1, 4'd5, EN_MDR,  SL_MEM, 0));
    vecs.push_back(mk(1, 6'h23, 6'h00, 0, 1, 4'd9, EN_REG,  SL_WBM, 0));
    // BEQ taken / not taken, BNE taken / not taken
    add_fd(6'h04, 6'h00, 1);
    vecs.push_back(mk(1, 6'h04, 6'h00, 1, 1, 4'd10, EN_PC, SL_BR, 0));
    add_fd(6'h04, 6'h00, 0);
    vecs.push_back(mk(1, 6'h04, 6'h00, 0, 1, 4'd10, EN_0,  SL_BR, 0));
    add_fd(6'h05, 6'h00, 0);
    vecs.push_back(mk(1, 6'h05, 6'h00, 0, 1, 4'd10, EN_PC, SL_BR, 0));
    add_fd(6'h05, 6'h00, 1);
    vecs.push_back(mk(1, 6'h05, 6'h00, 1, 1, 4'd10, EN_0,  SL_BR, 0));
    // J, JAL, JR
    add_fd(6'h02, 6'h00, 0);
    vecs.push_back(mk(1, 6'h02, 6'h00, 0, 1, 4'd11, EN_PC,  SL_J,   0));
    add_fd(6'h03, 6'h00, 0);
    vecs.push_back(mk(1, 6'h03, 6'h00, 0, 1, 4'd11, EN_JAL, SL_JAL, 0));
    add_fd(6'h00, 6'h08, 0);
    vecs.push_back(mk(1, 6'h00, 6'h08, 0, 1, 4'd11, EN_PC,  SL_JR,  0));
    // unsupported opcode -> HALT
    add_fd(6'h3F, 6'h00, 0);
    vecs.push_back(mk(1, 6'h3F, 6'h00, 0, 1, 4'd12, EN_0, SL_0, 1));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // HALT is absorbing: 20 cycles with a fetchable opcode and memready high
    for (int i = 0; i < 20; i++)
      apply(mk(1, 6'h00, 6'h20, 1, 1, 4'd12, EN_0, SL_0, 1), 1000 + i);

    // reset recovers; then R-type with unknown funct also halts
    apply(mk(0, 6'h00, 6'h01, 0, 1, 4'd0, EN_0, SL_0, 0), 2000);
    apply(mk(1, 6'h00, 6'h01, 0, 1, 4'd0, EN_FET, SL_FET, 0), 2001);
    apply(mk(1, 6'h00, 6'h01, 0, 1, 4'd1, EN_DEC, SL_DEC, 0), 2002);
    apply(mk(1, 6'h00, 6'h01, 0, 1, 4'd12, EN_0, SL_0, 1), 2003);
    apply(mk(1, 6'h00, 6'h01, 0, 1, 4'd12, EN_0, SL_0, 1), 2004);

    // reset in MEMWRITE with memready low drops memwe without a clock edge
    apply(mk(0, 6'h2B, 6'h00, 0, 1, 4'd0, EN_0, SL_0, 0), 3000);
    apply(mk(1, 6'h2B, 6'h00, 0, 1, 4'd0, EN_FET, SL_FET, 0), 3001);
    apply(mk(1, 6'h2B, 6'h00, 0, 1, 4'd1, EN_DEC, SL_DEC, 0), 3002);
    apply(mk(1, 6'h2B, 6'h00, 0, 1, 4'd4, EN_ALUO, SL_EXI, 0), 3003);
    bus.memready = 1'b0;
    @(negedge clk);
    check("memwr_state", 3004, 16'(bus.state), 16'd6);
    check("memwe_before_reset", 3004, 16'(bus.memwe), 16'd1);
    #1 resetn = 1'b0;
    #1;
    check("memwe_async_reset", 3005, 16'(bus.memwe), 16'd0);
    check("state_async_reset", 3005, 16'(bus.state), 16'd0);
    check("enables_async_reset", 3005, 16'(en_act), 16'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    bus.memready = 1'b1;
    @(negedge clk);
    check("first_fetch_state", 3006, 16'(bus.state), 16'd0);
    check("first_fetch_en", 3006, 16'(en_act), 16'(EN_FET));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
